// File: rtl/cpu_pkg.sv
// Shared CPU definitions: jump control encoding, sequencer states and default addresses.
package cpu_pkg;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_ABS = 2'b01;
    localparam logic [1:0] JMP_RSV = 2'b10;
    localparam logic [1:0] JMP_REG = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } seq_state_e;

    localparam logic [7:0] DEF_START_ADDR = 8'h00;
    localparam logic [7:0] DEF_J_TARGET   = 8'h3F;
    localparam logic [7:0] DEF_HALT_ADDR  = 8'hFF;

endpackage

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Combinational next-PC selection from decoder jump/branch controls and datapath inputs.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     OFF_W    = 6,
    parameter logic [PC_W-1:0] J_TARGET = DEF_J_TARGET
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             branch,
    input  logic [1:0]       jump,
    input  logic             cond_true,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  jr_target,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_ext;

    assign pc_inc  = pc + PC_W'(1);
    assign off_ext = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};

    // Jumps outrank branches; the reserved encoding falls through to sequential.
    always_comb begin
        next_pc = pc_inc;
        if (jump == JMP_REG) begin
            next_pc = jr_target;
        end else if (jump == JMP_ABS) begin
            next_pc = J_TARGET;
        end else if (branch && cond_true) begin
            next_pc = pc_inc + off_ext;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC/fetch sequencer: start/done program handshake, next-PC update and retired-instruction count.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W       = 8,
    parameter int unsigned     OFF_W      = 6,
    parameter logic [PC_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [PC_W-1:0] J_TARGET   = DEF_J_TARGET,
    parameter logic [PC_W-1:0] HALT_ADDR  = DEF_HALT_ADDR,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             branch,
    input  logic [1:0]       jump,
    input  logic             cond_true,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  jr_target,
    output logic [PC_W-1:0]  pc,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [PC_W-1:0] next_pc;

    next_pc_sel #(
        .PC_W     (PC_W),
        .OFF_W    (OFF_W),
        .J_TARGET (J_TARGET)
    ) u_next_pc_sel (
        .pc        (pc_q),
        .branch    (branch),
        .jump      (jump),
        .cond_true (cond_true),
        .br_off    (br_off),
        .jr_target (jr_target),
        .next_pc   (next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StRun;
                    pc_d      = START_ADDR;
                    retired_d = '0;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (retired_q != {CNT_W{1'b1}}) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    // The halt instruction retires but the PC parks on it.
                    if (pc_q == HALT_ADDR) begin
                        state_d = StDone;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= START_ADDR;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign pc          = pc_q;
    assign retired     = retired_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign instr_valid = (state_q == StRun) && !stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against an abstract program-flow model.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       branch;
    logic [1:0] jump;
    logic       cond_true;
    logic [5:0] br_off;
    logic [7:0] jr_target;
    logic [7:0] pc;
    logic       instr_valid;
    logic       busy;
    logic       done;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    // Model: 0 idle, 1 running, 2 finished.
    int       m_state;
    logic [7:0] m_pc;
    int       m_ret;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .cond_true   (cond_true),
        .br_off      (br_off),
        .jr_target   (jr_target),
        .pc          (pc),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    function automatic int sext_off(input logic [5:0] o);
        return o[5] ? int'(o) - 64 : int'(o);
    endfunction

    function automatic logic [7:0] model_target();
        int t;
        if (jump == 2'd3) t = int'(jr_target);
        else if (jump == 2'd1) t = 'h3F;
        else if (branch && cond_true) t = int'(m_pc) + 1 + sext_off(br_off);
        else t = int'(m_pc) + 1;
        return 8'(((t % 256) + 256) % 256);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = 8'h00;
        m_ret   = 0;
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; branch = 0; jump = 2'd0;
        cond_true = 0; br_off = 6'd0; jr_target = 8'd0;
    endtask

    // Advance one clock; model consumes the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (m_state == 1) begin
                if (!stall) begin
                    if (m_ret < 65535) m_ret = m_ret + 1;
                    if (m_pc == 8'hFF) m_state = 2;
                    else m_pc = model_target();
                end
            end else if (start) begin
                m_state = 1;
                m_pc    = 8'h00;
                m_ret   = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        #12;
        total++;
        if (pc !== 8'h00 || retired !== 16'd0) begin
            bad++;
            $display("FAIL reset_pc_cnt: pc=%h retired=%0d want pc=00 retired=0", pc, retired);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b done=%b valid=%b want 0 0 0", busy, done, instr_valid);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_sequential();
        tick();
        tick();
        start = 1;
        tick();
        start = 0;
        total++;
        if (pc !== 8'h00 || retired !== 16'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start: pc=%h retired=%0d busy=%b want 00 0 1", pc, retired, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) start = 1;  // must be ignored while running
            tick();
            start = 0;
            total++;
            if (pc !== m_pc || retired !== 16'(m_ret) || pc !== 8'(i) || busy !== 1'b1) begin
                bad++;
                $display("FAIL seq_step%0d: pc=%h retired=%0d busy=%b want pc=%h retired=%0d busy=1",
                         i, pc, retired, busy, 8'(i), i);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_valid: instr_valid=%b want 0", instr_valid);
            end
            tick();
            total++;
            if (pc !== 8'h05 || retired !== 16'd5 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: pc=%h retired=%0d busy=%b want 05 5 1", pc, retired, busy);
            end
        end
        stall = 0;
        #1;
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_valid: instr_valid=%b want 1", instr_valid);
        end
        tick();
        total++;
        if (pc !== 8'h06 || retired !== 16'd6) begin
            bad++;
            $display("FAIL stall_resume: pc=%h retired=%0d want 06 6", pc, retired);
        end
    endtask

    task automatic run_to(input logic [7:0] target);
        int n = 0;
        idle_inputs();
        while (pc !== target && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (pc !== target) begin
            bad++;
            $display("FAIL run_to: pc=%h want %h (timeout)", pc, target);
        end
    endtask

    task automatic test_branch();
        run_to(8'h10);
        branch = 1; cond_true = 1; br_off = 6'h3D;
        tick();
        idle_inputs();
        total++;
        if (pc !== 8'h0E || pc !== m_pc) begin
            bad++;
            $display("FAIL branch_taken: pc=%h want 0E", pc);
        end
        run_to(8'h10);
        branch = 1; cond_true = 0; br_off = 6'h3D;
        tick();
        idle_inputs();
        total++;
        if (pc !== 8'h11) begin
            bad++;
            $display("FAIL branch_not_taken: pc=%h want 11", pc);
        end
    endtask

    task automatic test_jump();
        run_to(8'h20);
        jump = 2'd1;
        tick();
        total++;
        if (pc !== 8'h3F) begin
            bad++;
            $display("FAIL jump_abs: pc=%h want 3F", pc);
        end
        jump = 2'd3; jr_target = 8'hA5;
        tick();
        total++;
        if (pc !== 8'hA5) begin
            bad++;
            $display("FAIL jump_reg: pc=%h want A5", pc);
        end
        jump = 2'd3; jr_target = 8'h33; branch = 1; cond_true = 1; br_off = 6'h05;
        tick();
        total++;
        if (pc !== 8'h33) begin
            bad++;
            $display("FAIL jump_over_branch: pc=%h want 33", pc);
        end
        idle_inputs();
        jump = 2'd2;
        tick();
        idle_inputs();
        total++;
        if (pc !== 8'h34) begin
            bad++;
            $display("FAIL jump_reserved: pc=%h want 34", pc);
        end
    endtask

    task automatic test_full_run();
        run_to(8'hFF);
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL first_done: done=%b busy=%b want 1 0", done, busy);
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i < 255) begin
                total++;
                if (pc !== m_pc || retired !== 16'(m_ret) || done !== 1'b0) begin
                    bad++;
                    $display("FAIL full_step%0d: pc=%h retired=%0d done=%b want %h %0d 0",
                             i, pc, retired, done, m_pc, m_ret);
                end
            end
        end
        total++;
        if (done !== 1'b1 || retired !== 16'd256 || pc !== 8'hFF || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_done: done=%b retired=%0d pc=%h busy=%b want 1 256 FF 0",
                     done, retired, pc, busy);
        end
        tick();
        tick();
        total++;
        if (done !== 1'b1 || pc !== 8'hFF || retired !== 16'd256) begin
            bad++;
            $display("FAIL done_hold: done=%b pc=%h retired=%0d want 1 FF 256", done, pc, retired);
        end
        start = 1;
        tick();
        start = 0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || pc !== 8'h00 || retired !== 16'd0) begin
            bad++;
            $display("FAIL restart: done=%b busy=%b pc=%h retired=%0d want 0 1 00 0",
                     done, busy, pc, retired);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            branch    = 1'($urandom);
            cond_true = 1'($urandom);
            jump      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            br_off    = 6'($urandom);
            jr_target = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            #1;
            total++;
            if (instr_valid !== (m_state == 1 && !stall)) begin
                bad++;
                $display("FAIL rand_valid%0d: instr_valid=%b want %b", i, instr_valid,
                         (m_state == 1 && !stall));
            end
            tick();
            total++;
            if (pc !== m_pc || retired !== 16'(m_ret) || busy !== (m_state == 1) ||
                done !== (m_state == 2)) begin
                bad++;
                $display("FAIL rand%0d: pc=%h retired=%0d busy=%b done=%b want %h %0d %b %b",
                         i, pc, retired, busy, done, m_pc, m_ret, m_state == 1, m_state == 2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        rst_n = 0;
        #3;
        rst_n = 1;
        model_reset();
        @(negedge clk);
        start = 1;
        tick();
        start = 0;
        jump = 2'd1;
        tick();
        jump = 2'd0;
        tick();
        total++;
        if (pc !== 8'h40 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: pc=%h busy=%b want 40 1", pc, busy);
        end
        #2;
        rst_n = 0;
        #1;
        total++;
        if (pc !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || retired !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: pc=%h busy=%b done=%b retired=%0d want 00 0 0 0",
                     pc, busy, done, retired);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        total++;
        if (pc !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: pc=%h busy=%b want 00 0", pc, busy);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_full_run();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
